acc_fp_norm_acc: RTL
====================

// Module: acc_fp_norm_acc
// PURPOSE
// Downstream stage of the FP accumulate datapath.
// - Consumes the aligned sign/exponent/mantissa pair from the alignment stage.
// - Adds the pair, then normalises and rounds (RNE) into the 16-bit accumulator
//   format {sgn[15], exp[14:11], frac[10:0]}.
// - Holds the running accumulator and feeds it back as the alignment stage's ops input.
// - Emits the final sum on a valid/ready port when the last term has been absorbed.
// PARAMETERS
// EXP_W   4   accumulator exponent width
// FRAC_W  11  stored fraction width (hidden 1 implied unless word[14:0]==0)
// ALN_W   17  aligned mantissa width; two's complement; bit15 = 1.0, bits14:4 = frac
// SAT_EN  1   1: saturate on exponent overflow; 0: wrap (debug only)
// PORTS
// clk        in   1   clock
// rst        in   1   synchronous, active-high reset
// clr        in   1   synchronous: zero accumulator, drop in-flight term
// in_valid   in   1   aligned term present
// in_ready   out  1   term accepted when in_valid && in_ready
// in_last    in   1   accepted term is the final one of this accumulation
// align_sgn  in   2   [1]=operand signs differ, [0]=sign of larger-exp operand
// align_exp  in   4   common exponent
// align_man0 in   17  aligned accumulator mantissa (two's complement)
// align_man1 in   17  aligned product mantissa (two's complement)
// acc_ops    out  16  current accumulator word, fed back to the alignment stage
// out_valid  out  1   final sum available
// out_ready  in   1   consumer accepts out_data
// out_data   out  16  final accumulated value
// ovf_flag   out  1   sticky: an exponent overflow saturated
// unf_flag   out  1   sticky: a result was flushed to zero
// BEHAVIOUR
// - Reset values: acc=0x0000, out_valid=0, out_data=0x0000, flags=0, state=ACC.
//   in_ready=0 while rst is high.
// - FSM:
//   ACC -(accept)-> NORM;  NORM -(!s1_last)-> ACC;  NORM -(s1_last)-> OUT;
//   OUT -(out_ready)-> ACC with acc<=0.
// - in_ready = (state==ACC) && !clr && !rst. One term in flight, because acc feeds back.
// - Timing, term accepted at cycle T:
//   - T: S1 regs <= {sum, align_sgn, align_exp, in_last}.
//   - T+1: S2 normalises; acc updated at end of T+1.
//   - T+2: acc_ops valid and in_ready high again.
// - Throughput: one term per 2 cycles.
// - Arithmetic (S1): sum[17:0] = sext(man0) + sext(man1).
// - Sign (S2):
//   - sum<0: mag = -sum, sign = ~align_sgn[0].
//   - sum>=0: mag = sum, sign = align_sgn[0].
// - Zero: mag==0 gives result 0x0000 (sign +).
// - Normalise: p = leading-one index of mag[16:0]; e = exp + (p - 15), computed 6-bit signed.
// - Fraction and rounding:
//   - frac = the 11 bits below p.
//   - guard = next bit; sticky = OR of the rest; bits below 0 are zero.
//   - RNE: increment when guard && (sticky || lsb).
//   - A fraction carry-out gives e+1 and frac=0.
// - Exponent range:
//   - e > 15: result {sign, 0x7FFF[14:0]} and set ovf_flag (SAT_EN=1).
//   - e < 0, or e==0 with frac==0 (collides with zero code): result 0x0000 and set unf_flag.
// - OUT: out_valid=1 and out_data=acc, held stable until out_ready.
//   In the out_ready cycle: out_valid<=0, acc<=0, state<=ACC. Flags are not cleared.
// - clr (priority below rst, above everything else):
//   - state<=ACC, acc<=0, S1 invalid, flags<=0, out_valid<=0.
//   - A pending output is dropped, even if out_ready is high in the same cycle.
//   - A term offered in the clr cycle is not accepted.
// - rst mid-operation behaves as clr.
// - in_last on an accepted term always yields exactly one out_valid transfer, even if the
//   result is zero.
// STRUCTURE
// - Shared package acc_fp_pkg: EXP_W, FRAC_W, ALN_W, EXP_MAX, ZERO_WORD, SAT_WORD
//   constants; state typedef {ACC, NORM, OUT}.
// - Sub-module acc_fp_lzd: 17-bit leading-one detector with outputs pos[4:0] and zero.
// - Normalise and round stay inline.
// TESTING
// 1. Add: exp=8, sgn=00, man0=0x08000, man1=0x08000 (1.0+1.0) -> acc=0x4800 at T+2.
// 2. Cancel: exp=8, sgn=10, man0=0x08000, man1=0x18000 -> acc=0x0000, unf_flag=0.
// 3. Sign flip: exp=8, sgn=11, man0=0x08000, man1=0x1C000 -> acc=0xB800.
// 4. RNE: exp=8, sgn=00, man0=0:
//    - man1=0x08008 -> 0x4000 (tie, even).
//    - man1=0x08018 -> 0x4002.
// 5. Overflow: exp=15, sgn=00, man0=man1=0x0FFF0 -> acc=0x7FFF, ovf_flag=1.
// 6. Handshake:
//    - Three terms with in_last on the third, out_ready low for 3 cycles.
//      -> out_valid held and out_data stable; after the transfer acc=0 and in_ready=1.
//    - clr during OUT -> out_valid=0 next cycle.

Source files
------------

// File: rtl/acc_fp_pkg.sv
// Shared constants and state encoding for the FP accumulate datapath.
package acc_fp_pkg;
  localparam int unsigned EXP_W  = 4;
  localparam int unsigned FRAC_W = 11;
  localparam int unsigned ALN_W  = 17;
  localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;

  localparam int EXP_MAX = 15;

  localparam logic [WORD_W-1:0] ZERO_WORD = 16'h0000;
  localparam logic [WORD_W-2:0] SAT_WORD  = 15'h7FFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_ACC  = 2'd0;
  localparam state_t ST_NORM = 2'd1;
  localparam state_t ST_OUT  = 2'd2;
endpackage

// File: rtl/acc_fp_norm_acc_if.sv
// Term input, accumulator feedback and result handshake of the normalise/accumulate stage.
interface acc_fp_norm_acc_if;
  import acc_fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        align_sgn;
  logic [EXP_W-1:0]  align_exp;
  logic [ALN_W-1:0]  align_man0;
  logic [ALN_W-1:0]  align_man1;
  logic [WORD_W-1:0] acc_ops;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (
    output in_valid, in_last, align_sgn, align_exp, align_man0, align_man1, out_ready,
    input  in_ready, acc_ops, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, align_sgn, align_exp, align_man0, align_man1, out_ready,
    output in_ready, acc_ops, out_valid, out_data
  );
endinterface

// File: rtl/acc_fp_lzd.sv
// 17-bit leading-one detector: index of the highest set bit, plus an all-zero flag.
module acc_fp_lzd
  import acc_fp_pkg::*;
(
  input  logic [ALN_W-1:0] i_data,
  output logic [4:0]       o_pos,
  output logic             o_zero
);

  always_comb begin
    o_pos = '0;
    for (int unsigned i = 0; i < ALN_W; i++) begin
      if (i_data[i]) o_pos = 5'(i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/acc_fp_norm_acc.sv
// Adds the aligned pair, normalises and rounds (RNE) into the 16-bit accumulator,
// holds the running sum for feedback, and emits the final sum on a valid/ready port.
module acc_fp_norm_acc
  import acc_fp_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  acc_fp_norm_acc_if.slave   bus,
  output logic               o_ovf_flag,
  output logic               o_unf_flag
);

  state_t              r_state;
  logic [WORD_W-1:0]   r_acc;
  logic [ALN_W:0]      r_s1_sum;
  logic                r_s1_sgn;
  logic [EXP_W-1:0]    r_s1_exp;
  logic                r_s1_last;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_ovf;
  logic                r_unf;

  logic [ALN_W:0]      w_sum;
  logic                w_accept;
  logic                w_neg;
  logic                w_sign;
  logic [ALN_W-1:0]    w_mag;
  logic [4:0]          w_pos;
  logic                w_zero;
  logic [28:0]         w_shift;
  logic [FRAC_W-1:0]   w_frac;
  logic                w_guard;
  logic                w_sticky;
  logic                w_inc;
  logic [FRAC_W:0]     w_frac_r;
  logic [FRAC_W-1:0]   w_frac_f;
  logic signed [5:0]   w_exp_e;
  logic signed [5:0]   w_exp_f;
  logic [WORD_W-1:0]   w_res;
  logic                w_ovf;
  logic                w_unf;

  assign bus.in_ready  = (r_state == ST_ACC) && !i_clr && !i_rst;
  assign bus.acc_ops   = r_acc;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_ovf_flag    = r_ovf;
  assign o_unf_flag    = r_unf;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_sum    = {bus.align_man0[ALN_W-1], bus.align_man0}
                  + {bus.align_man1[ALN_W-1], bus.align_man1};

  assign w_neg  = r_s1_sum[ALN_W];
  assign w_sign = w_neg ? ~r_s1_sgn : r_s1_sgn;
  assign w_mag  = w_neg ? ALN_W'(-r_s1_sum) : r_s1_sum[ALN_W-1:0];

  acc_fp_lzd u_lzd (
    .i_data (w_mag),
    .o_pos  (w_pos),
    .o_zero (w_zero)
  );

  // Leading one lands on bit 28; 12 zero bits below the LSB keep guard/sticky defined.
  assign w_shift  = {w_mag, 12'b0} << (5'd16 - w_pos);
  assign w_frac   = w_shift[27:17];
  assign w_guard  = w_shift[16];
  assign w_sticky = |w_shift[15:0];
  assign w_inc    = w_guard && (w_sticky || w_frac[0]);
  assign w_frac_r = {1'b0, w_frac} + 12'(w_inc);
  assign w_frac_f = w_frac_r[FRAC_W] ? '0 : w_frac_r[FRAC_W-1:0];

  assign w_exp_e = $signed({2'b00, r_s1_exp}) + $signed({1'b0, w_pos}) - 6'sd15;
  assign w_exp_f = w_exp_e + $signed({5'b0, w_frac_r[FRAC_W]});

  always_comb begin
    w_res = {w_sign, w_exp_f[EXP_W-1:0], w_frac_f};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (w_zero) begin
      w_res = ZERO_WORD;
    end else if (w_exp_f > 6'(EXP_MAX)) begin
      if (SAT_EN) begin
        w_res = {w_sign, SAT_WORD};
        w_ovf = 1'b1;
      end
    end else if (w_exp_f < 6'sd0 || (w_exp_f == 6'sd0 && w_frac_f == '0)) begin
      // Exponent 0 with zero fraction would alias the zero code, so flush it.
      w_res = ZERO_WORD;
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_state     <= ST_ACC;
      r_acc       <= ZERO_WORD;
      r_s1_sum    <= '0;
      r_s1_sgn    <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= ZERO_WORD;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_s1_sum  <= w_sum;
            r_s1_sgn  <= bus.align_sgn[0];
            r_s1_exp  <= bus.align_exp;
            r_s1_last <= bus.in_last;
            r_state   <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_acc <= w_res;
          r_ovf <= r_ovf | w_ovf;
          r_unf <= r_unf | w_unf;
          if (r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_state     <= ST_OUT;
          end else begin
            r_state <= ST_ACC;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= ZERO_WORD;
            r_state     <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

endmodule
